// File: rtl/mips_muldiv_unit.sv
// HI/LO multiply/divide unit: shift-add multiplier and restoring divider, 1 bit per cycle.
// Latency: WIDTH+1 busy cycles for MULT/DIV, 1 cycle for divide-by-zero, MTHI/MTLO write at acceptance.
// Backpressure: start_i is ignored while busy_o is high; the requester must hold the request.
//
// Ports:
//   clk, reset_i          clock, synchronous active-high reset
//   start_i, op_i         request and opcode (0 MULT,1 MULTU,2 DIV,3 DIVU,4 MTHI,5 MTLO,6-7 NOP)
//   rs_i, rt_i            operands / MTHI-MTLO data, sampled only when a request is accepted
//   busy_o, done_o        op in flight; one-cycle pulse when fresh results sit in HI/LO
//   hi_o, lo_o            architectural HI and LO registers
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] rs_i,
    input  logic [WIDTH-1:0] rt_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    // MUL: {partial product high, multiplier shifting out / product low}
    // DIV: {partial remainder, dividend shifting out / quotient shifting in}
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   b_q;        // multiplicand magnitude or divisor magnitude
    logic               neg_q;
    logic               rem_neg_q;
    logic               is_div_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               op_is_mul, op_is_div, op_signed, div_by_zero;
    logic               rs_neg, rt_neg;
    logic [WIDTH-1:0]   rs_mag, rt_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift, div_trial;
    logic               div_ok;
    logic [WIDTH-1:0]   rem_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        op_is_mul   = (op_i == OP_MULT) || (op_i == OP_MULTU);
        op_is_div   = (op_i == OP_DIV)  || (op_i == OP_DIVU);
        op_signed   = (op_i == OP_MULT) || (op_i == OP_DIV);
        div_by_zero = (rt_i == '0);
        rs_neg      = op_signed & rs_i[WIDTH-1];
        rt_neg      = op_signed & rt_i[WIDTH-1];
        // MIN stays MIN here, which is also its correct unsigned magnitude
        rs_mag      = rs_neg ? (~rs_i + 1'b1) : rs_i;
        rt_mag      = rt_neg ? (~rt_i + 1'b1) : rt_i;

        mul_sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : '0)};

        // The remainder is always below the divisor, so the top bit of the
        // trial difference is a reliable borrow flag.
        div_shift   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_trial   = div_shift - {1'b0, b_q};
        div_ok      = ~div_trial[WIDTH];
        rem_next    = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];

        // MIN / -1 falls out naturally: quotient magnitude 2^(W-1) negates to itself.
        prod_fix    = neg_q ? (~acc_q + 1'b1) : acc_q;
        quo_fix     = neg_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        rem_fix     = rem_neg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && op_is_mul) begin
                    state_d = S_MUL;
                end else if (start_i && op_is_div && !div_by_zero) begin
                    state_d = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            b_q       <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            is_div_q  <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        if (op_is_mul || (op_is_div && !div_by_zero)) begin
                            acc_q     <= op_is_mul ? {{WIDTH{1'b0}}, rt_mag} : {{WIDTH{1'b0}}, rs_mag};
                            b_q       <= op_is_mul ? rs_mag : rt_mag;
                            cnt_q     <= CNT_W'(WIDTH - 1);
                            neg_q     <= rs_neg ^ rt_neg;
                            rem_neg_q <= rs_neg;
                            is_div_q  <= op_is_div;
                        end else if (op_is_div) begin
                            hi_q   <= '0;
                            lo_q   <= '0;
                            done_q <= 1'b1;
                        end else if (op_i == OP_MTHI) begin
                            hi_q <= rs_i;
                        end else if (op_i == OP_MTLO) begin
                            lo_q <= rs_i;
                        end
                    end
                end
                S_MUL: begin
                    acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
                    cnt_q <= cnt_q - 1'b1;
                end
                S_DIV: begin
                    acc_q <= {rem_next, acc_q[WIDTH-2:0], div_ok};
                    cnt_q <= cnt_q - 1'b1;
                end
                S_FIX: begin
                    if (is_div_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy_o = (state_q != S_IDLE);
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
module tb_mips_muldiv_unit;
    logic        clk;
    logic        reset_i;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] rs_i, rt_i;
    logic        busy_o, done_o;
    logic [31:0] hi_o, lo_o;

    int n_checks = 0;
    int n_fail   = 0;

    mips_muldiv_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_i (reset_i),
        .start_i (start_i),
        .op_i    (op_i),
        .rs_i    (rs_i),
        .rt_i    (rt_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    logic        m_on = 1'b0;
    int          m_left = 0;          // busy cycles still to go
    logic        m_done = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [31:0] m_res_hi, m_res_lo;

    // Architectural result of a MULT/MULTU/DIV/DIVU with plain arithmetic.
    task automatic arith(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo);
        int          sa, sb;
        longint      sp;
        logic [63:0] up;
        sa = a;
        sb = b;
        hi = '0;
        lo = '0;
        case (op)
            3'd0: begin sp = longint'(sa) * longint'(sb); up = sp; hi = up[63:32]; lo = up[31:0]; end
            3'd1: begin up = {32'd0, a} * {32'd0, b};     hi = up[63:32]; lo = up[31:0]; end
            3'd2: begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000; hi = '0;
                end else begin
                    lo = sa / sb; hi = sa % sb;
                end
            end
            3'd3: begin lo = a / b; hi = a % b; end
            default: ;
        endcase
    endtask

    always @(posedge clk) begin
        m_done = 1'b0;
        if (reset_i) begin
            m_on = 1'b1; m_left = 0; m_hi = '0; m_lo = '0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hi = m_res_hi; m_lo = m_res_lo; m_done = 1'b1;
            end
        end else if (start_i) begin
            if (op_i <= 3'd1 || (op_i <= 3'd3 && rt_i != 0)) begin
                arith(op_i, rs_i, rt_i, m_res_hi, m_res_lo);
                m_left = 33;
            end else if (op_i <= 3'd3) begin
                m_hi = '0; m_lo = '0; m_done = 1'b1;
            end else if (op_i == 3'd4) begin
                m_hi = rs_i;
            end else if (op_i == 3'd5) begin
                m_lo = rs_i;
            end
        end
    end

    // One compare process: every cycle once reset has been applied.
    always @(negedge clk) begin
        if (m_on) begin
            chk("busy_o", busy_o, (m_left > 0));
            chk("done_o", done_o, m_done);
            chk("hi_o",   hi_o,   m_hi);
            chk("lo_o",   lo_o,   m_lo);
        end
    end

    // ---------------- stimulus ----------------
    // Called just after a negedge; returns at the negedge where done_o is high.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        start_i = 1'b1; op_i = op; rs_i = a; rt_i = b;
        @(negedge clk);
        start_i = 1'b0; rs_i = 32'hA5A5_A5A5; rt_i = 32'h5A5A_5A5A;
        lat = 1;
        while (done_o !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    vec_t vecs[6] = '{
        '{3'd2, 32'd7,          32'hFFFF_FFFE},
        '{3'd2, 32'hFFFF_FFF8,  32'hFFFF_FFFD},
        '{3'd0, 32'h8000_0000,  32'h8000_0000},
        '{3'd1, 32'h1234_5678,  32'h9ABC_DEF0},
        '{3'd3, 32'hFFFF_FFFF,  32'd1},
        '{3'd0, 32'h7FFF_FFFF,  32'hFFFF_FFFF}
    };

    initial begin
        int lat;
        int dcount;
        reset_i = 1'b1; start_i = 1'b0; op_i = '0; rs_i = '0; rt_i = '0;
        repeat (2) @(negedge clk);
        chk("reset_hi", hi_o, 0);
        chk("reset_lo", lo_o, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_done", done_o, 0);
        reset_i = 1'b0;
        @(negedge clk);

        run_op(3'd0, 32'hFFFF_FFFD, 32'd5, lat);
        chk("mult_lat", lat, 34);
        chk("mult_hi", hi_o, 32'hFFFF_FFFF);
        chk("mult_lo", lo_o, 32'hFFFF_FFF1);

        // issued in the done cycle: back-to-back acceptance
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        chk("multu_lat", lat, 34);
        chk("multu_hi", hi_o, 32'hFFFF_FFFE);
        chk("multu_lo", lo_o, 32'h0000_0001);

        run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        chk("mult_m1_hi", hi_o, 0);
        chk("mult_m1_lo", lo_o, 1);

        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, lat);
        chk("div_lat", lat, 34);
        chk("div_lo", lo_o, 32'hFFFF_FFFD);
        chk("div_hi", hi_o, 32'hFFFF_FFFF);

        run_op(3'd3, 32'd100, 32'd7, lat);
        chk("divu_lo", lo_o, 14);
        chk("divu_hi", hi_o, 2);

        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        chk("div_ovf_lo", lo_o, 32'h8000_0000);
        chk("div_ovf_hi", hi_o, 0);

        run_op(3'd3, 32'd42, 32'd0, lat);
        chk("div0_lat", lat, 1);
        chk("div0_hi", hi_o, 0);
        chk("div0_lo", lo_o, 0);

        // MTHI then MTLO on consecutive cycles
        start_i = 1'b1; op_i = 3'd4; rs_i = 32'h1234;
        @(negedge clk);
        op_i = 3'd5; rs_i = 32'h5678;
        @(negedge clk);
        start_i = 1'b0;
        chk("mthi", hi_o, 32'h1234);
        chk("mtlo", lo_o, 32'h5678);
        chk("mt_no_done", done_o, 0);
        @(negedge clk);

        // MTLO while a MULT is in flight is dropped
        start_i = 1'b1; op_i = 3'd0; rs_i = 32'd3; rt_i = 32'd4;
        @(negedge clk);
        start_i = 1'b0;
        repeat (5) @(negedge clk);
        start_i = 1'b1; op_i = 3'd5; rs_i = 32'hDEAD;
        @(negedge clk);
        start_i = 1'b0;
        chk("busy_mtlo_lo", lo_o, 32'h5678);
        lat = 0;
        while (done_o !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("busy_mtlo_lat", lat, 27);
        chk("busy_mult_lo", lo_o, 12);
        chk("busy_mult_hi", hi_o, 0);

        // reset at iteration 10 of MULTU 7*9
        start_i = 1'b1; op_i = 3'd1; rs_i = 32'd7; rt_i = 32'd9;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        chk("abort_busy", busy_o, 0);
        chk("abort_hi", hi_o, 0);
        chk("abort_lo", lo_o, 0);
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_o === 1'b1) dcount++;
        end
        chk("abort_no_done", dcount, 0);

        run_op(3'd1, 32'd7, 32'd9, lat);
        chk("fresh_lo", lo_o, 63);
        chk("fresh_hi", hi_o, 0);

        // further vectors checked by the model alone
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            chk("vec_lat", lat, 34);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
Parametrised, multi-cycle HI/LO multiply/divide unit for the MIPS core. It replaces the single-cycle combinational mult/div path with a shift-add multiplier and a restoring divider that each resolve 1 bit per cycle. It also owns the HI/LO architectural registers and the MTHI/MTLO writes. The core stalls MFHI/MFLO and new HI/LO ops while busy_o is high.

Parameters:
- WIDTH, 32, operand width and HI/LO register width.
- CNT_W, $clog2(WIDTH), width of the iteration counter (derived, not overridden).

Ports:
- clk  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- start_i  in  1  request; sampled at a rising edge only when in IDLE.
- op_i  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6-7 are a NOP.
- rs_i  in  WIDTH  multiplicand, dividend, or MTHI/MTLO data.
- rt_i  in  WIDTH  multiplier or divisor.
- busy_o  out  1  high while an arithmetic op is in flight (state != IDLE).
- done_o  out  1  one-cycle pulse; HI/LO are valid with new results in the same cycle.
- hi_o  out  WIDTH  HI register.
- lo_o  out  WIDTH  LO register.

Behaviour:
- Reset:
  - State goes to IDLE.
  - hi_o=0, lo_o=0, done_o=0, busy_o=0.
  - Counter and datapath registers are cleared.
  - Reset mid-operation aborts the op with no HI/LO update and no done_o.
- States: IDLE, MUL, DIV, FIX.
- IDLE with start_i=1:
  - op MULT/MULTU: latch operands, counter=WIDTH-1, go to MUL.
  - op DIV/DIVU with rt_i!=0: latch operands, counter=WIDTH-1, go to DIV.
  - op DIV/DIVU with rt_i==0: stay in IDLE. Next edge writes HI=0, LO=0; done_o pulses the following cycle. This is 1-cycle latency and busy_o never rises.
  - op MTHI/MTLO: next edge writes rs_i into HI or LO only. No busy_o, no done_o.
  - op 6/7: ignored.
- Signed ops (MULT, DIV):
  - Operands are converted to magnitudes at latch.
  - Latch records result sign neg_q = sign(rs) XOR sign(rt).
  - Latch records remainder sign rem_neg_q = sign(rs).
- Unsigned ops: magnitudes are the raw operands; neg_q=0, rem_neg_q=0.
- MUL state:
  - Each cycle adds the multiplicand to the 2*WIDTH partial product if the current multiplier LSB is 1, then shifts.
  - After WIDTH cycles (counter reaches 0), go to FIX.
- DIV state:
  - Restoring division, one quotient bit per cycle, MSB first.
  - After WIDTH cycles, go to FIX.
- FIX state (one cycle):
  - MUL result: if neg_q, negate the 2*WIDTH product (two's complement). HI=product[2W-1:W], LO=product[W-1:0].
  - DIV result: LO=quotient, negated if neg_q. HI=remainder, negated if rem_neg_q.
  - Division truncates toward zero.
  - Overflow case MIN/-1: LO=MIN, HI=0. No exception.
  - FIX then returns to IDLE; done_o=1 in the next cycle.
- Latency: start accepted at edge E0. busy_o is high for exactly WIDTH+1 cycles (WIDTH iterations plus FIX). HI/LO update at edge E(WIDTH+1); done_o is high in the cycle after that edge. For WIDTH=32 this is 33 busy cycles.
- Back-to-back: start_i is accepted in the cycle done_o is high, because the unit is in IDLE.
- start_i while busy_o=1:
  - Ignored entirely; this includes MTHI/MTLO.
  - The upstream stall is responsible for holding the request.
- Operand inputs are only sampled at start acceptance. rs_i/rt_i may change while busy.
- hi_o/lo_o hold their old values throughout an op until the FIX write.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=5 -> 33 cycles busy, then done_o with hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1.
- MULTU rs=rt=0xFFFFFFFF -> hi_o=0xFFFFFFFE, lo_o=0x00000001. Also check that MULT with the same operands gives hi_o=0, lo_o=1.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIVU rs=100, rt=7 -> lo_o=14, hi_o=2. DIV 0x80000000/0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
- DIVU rs=42, rt=0 -> busy_o stays 0, done_o one cycle later, hi_o=lo_o=0.
- MTHI 0x1234 then MTLO 0x5678 on consecutive cycles -> hi_o=0x1234, lo_o=0x5678, no done_o. MTLO issued during MULT busy -> ignored.
- Reset_i pulsed at iteration 10 of a MULTU 7*9 -> busy_o=0, hi_o=lo_o=0, no done_o. A fresh MULTU 7*9 afterwards -> lo_o=63.
